// File: rtl/des_pkg.sv
// DES S-box constants, the S1..S8 default tables and lookup helpers shared by
// the programmable S-box table and its lookup lanes.
package des_pkg;

   localparam int unsigned SBOX_ROWS    = 4;
   localparam int unsigned SBOX_COLS    = 16;
   localparam int unsigned SBOX_IN_W    = 6;
   localparam int unsigned SBOX_OUT_W   = 4;
   localparam int unsigned SBOX_ENTRIES = SBOX_ROWS * SBOX_COLS;
   localparam int unsigned SBOX_ADDR_W  = 6;
   localparam int unsigned SBOX_TBL_W   = SBOX_ENTRIES * SBOX_OUT_W;

   // One 64-bit word per {sbox, row}; column 0 is the most significant nibble.
   localparam logic [63:0] SBOX_ROM [32] = '{
      64'he4d12fb83a6c5907, 64'h0f74e2d1a6cb9538, 64'h41e8d62bfc973a50, 64'hfc8249175b3ea06d,
      64'hf18e6b34972dc05a, 64'h3d47f28ec01a69b5, 64'h0e7ba4d158c6932f, 64'hd8a13f42b67c05e9,
      64'ha09e63f51dc7b428, 64'hd709346a285ecbf1, 64'hd6498f30b12c5ae7, 64'h1ad069874fe3b52c,
      64'h7de3069a1285bc4f, 64'hd8b56f03472c1ae9, 64'ha690cb7df13e5284, 64'h3f06a1d8945bc72e,
      64'h2c417ab6853fd0e9, 64'heb2c47d150fa3986, 64'h421bad78f9c5630e, 64'hb8c71e2d6f09a453,
      64'hc1af92680d34e75b, 64'haf427c9561de0b38, 64'h9ef528c3704a1db6, 64'h432c95fabe17608d,
      64'h4b2ef08d3c975a61, 64'hd0b7491ae35c2f86, 64'h14bdc37eaf680592, 64'h6bd814a7950fe23c,
      64'hd2846fb1a93e50c7, 64'h1fd8a374c56b0e92, 64'h7b419ce206adf358, 64'h21e74a8dfc90356b
   };

   function automatic logic [SBOX_OUT_W-1:0] des_sbox_default(input logic [2:0] id,
                                                              input logic [1:0] row,
                                                              input logic [3:0] col);
      logic [63:0] r;
      r = SBOX_ROM[{id, row}];
      return r[{~col, 2'b00} +: SBOX_OUT_W];
   endfunction

   // Flattened default table: entry at address {row, col} sits at bits [4*addr +: 4].
   function automatic logic [SBOX_TBL_W-1:0] des_sbox_table(input logic [2:0] id);
      logic [SBOX_TBL_W-1:0] t;
      t = '0;
      for (int a = 0; a < int'(SBOX_ENTRIES); a++) begin
         t[a*SBOX_OUT_W +: SBOX_OUT_W] = des_sbox_default(id, 2'(a >> 4), 4'(a));
      end
      return t;
   endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// Single lookup lane: DES row/column decode of a 6-bit input and a 4-bit table mux.
module des_sbox_lane
   import des_pkg::*;
(
   input  logic [SBOX_TBL_W-1:0] tbl,
   input  logic [SBOX_IN_W-1:0]  din,
   output logic [SBOX_OUT_W-1:0] dout_c
);

   logic [SBOX_ADDR_W-1:0] addr;

   // Outer bits select the row, inner four bits the column.
   assign addr   = {din[5], din[0], din[4:1]};
   assign dout_c = tbl[{addr, 2'b00} +: SBOX_OUT_W];

endmodule

// File: rtl/des_sbox_prog.sv
// Programmable DES S-box: multi-lane lookup of a writable 64x4 table with
// readback and a background restore of the default contents.
module des_sbox_prog
   import des_pkg::*;
#(
   parameter int unsigned SBOX_ID = 0,
   parameter int unsigned LANES   = 1,
   parameter int unsigned OUT_REG = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          lk_valid,
   input  logic [SBOX_IN_W*LANES-1:0]    lk_data,
   output logic                          o_valid,
   output logic [SBOX_OUT_W*LANES-1:0]   o_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [2:0]                    wr_sel,
   input  logic [1:0]                    wr_row,
   input  logic [3:0]                    wr_col,
   input  logic [3:0]                    wr_data,
   input  logic                          rd_valid,
   input  logic [1:0]                    rd_row,
   input  logic [3:0]                    rd_col,
   output logic                          rd_rvalid,
   output logic [3:0]                    rd_data,
   input  logic                          restore_req,
   output logic                          busy
);

   localparam logic [SBOX_TBL_W-1:0] TBL_DEFAULT = des_sbox_table(3'(SBOX_ID));
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RESTORE = 1'b1;

   logic [0:0]                   state, state_nxt;
   logic [SBOX_ADDR_W-1:0]       idx, idx_nxt;
   logic [SBOX_TBL_W-1:0]        tbl;
   logic                         tbl_we;
   logic [SBOX_ADDR_W-1:0]       tbl_waddr;
   logic [SBOX_OUT_W-1:0]        tbl_wdata;
   logic [SBOX_OUT_W*LANES-1:0]  lane_data;

   assign busy     = (state == ST_RESTORE);
   assign wr_ready = !busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Restore walks every address once; requests arriving while busy are dropped.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (restore_req) begin
               state_nxt = ST_RESTORE;
               idx_nxt   = '0;
            end
         end
         ST_RESTORE: begin
            idx_nxt = idx + 6'd1;
            if (idx == 6'(SBOX_ENTRIES - 1)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Restore and user writes never collide because wr_ready is low while busy.
   always_comb begin
      tbl_we    = 1'b0;
      tbl_waddr = '0;
      tbl_wdata = '0;
      if (state == ST_RESTORE) begin
         tbl_we    = 1'b1;
         tbl_waddr = idx;
         tbl_wdata = TBL_DEFAULT[{idx, 2'b00} +: SBOX_OUT_W];
      end else if (wr_valid && wr_ready && (wr_sel == 3'(SBOX_ID))) begin
         tbl_we    = 1'b1;
         tbl_waddr = {wr_row, wr_col};
         tbl_wdata = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl <= TBL_DEFAULT;
      end else if (tbl_we) begin
         tbl[{tbl_waddr, 2'b00} +: SBOX_OUT_W] <= tbl_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_rvalid <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_rvalid <= rd_valid;
         if (rd_valid) begin
            rd_data <= tbl[{rd_row, rd_col, 2'b00} +: SBOX_OUT_W];
         end
      end
   end

   for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
      des_sbox_lane u_lane (
         .tbl    (tbl),
         .din    (lk_data[k*SBOX_IN_W +: SBOX_IN_W]),
         .dout_c (lane_data[k*SBOX_OUT_W +: SBOX_OUT_W])
      );
   end

   if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
         end else begin
            o_valid <= lk_valid;
            if (lk_valid) begin
               o_data <= lane_data;
            end
         end
      end
   end else begin : g_ocomb
      assign o_valid = lk_valid;
      assign o_data  = lane_data;
   end

endmodule

// File: tb/tb_des_sbox_prog.sv
// Scoreboard bench for des_sbox_prog with SBOX_ID=3 (DES S4), two lanes, registered output.
module tb_des_sbox_prog;

   localparam int unsigned SBOX_ID = 3;
   localparam int unsigned LANES   = 2;
   localparam int unsigned OUT_REG = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lk_valid;
   logic [11:0] lk_data;
   logic        o_valid;
   logic [7:0]  o_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_sel;
   logic [1:0]  wr_row;
   logic [3:0]  wr_col;
   logic [3:0]  wr_data;
   logic        rd_valid;
   logic [1:0]  rd_row;
   logic [3:0]  rd_col;
   logic        rd_rvalid;
   logic [3:0]  rd_data;
   logic        restore_req;
   logic        busy;

   des_sbox_prog #(.SBOX_ID(SBOX_ID), .LANES(LANES), .OUT_REG(OUT_REG)) dut (
      .clk(clk), .rst_n(rst_n),
      .lk_valid(lk_valid), .lk_data(lk_data), .o_valid(o_valid), .o_data(o_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_row(wr_row),
      .wr_col(wr_col), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_row(rd_row), .rd_col(rd_col),
      .rd_rvalid(rd_rvalid), .rd_data(rd_data),
      .restore_req(restore_req), .busy(busy)
   );

   always #5 clk = ~clk;

   // DES S4, row-major: address = {row, col}.
   logic [3:0] s4 [64] = '{
      4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14
   };
   logic [3:0] m_tbl [64];
   logic [7:0] lk_q [$];
   logic [3:0] rd_q [$];
   int checks = 0;
   int errors = 0;

   function automatic logic [5:0] addr_of(input logic [5:0] d);
      return {d[5], d[0], d[4:1]};
   endfunction

   function automatic logic [7:0] exp_lookup(input logic [11:0] d);
      return {m_tbl[addr_of(d[11:6])], m_tbl[addr_of(d[5:0])]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_defaults();
      for (int a = 0; a < 64; a++) m_tbl[a] = s4[a];
   endtask

   task automatic drive_lookup(input logic [11:0] d);
      lk_valid = 1'b1;
      lk_data  = d;
      lk_q.push_back(exp_lookup(d));
   endtask

   task automatic drive_write(input logic [2:0] sel, input logic [1:0] row,
                              input logic [3:0] col, input logic [3:0] data);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_row   = row;
      wr_col   = col;
      wr_data  = data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data: got %h want 00", o_data); end
      checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rd_rvalid: got %b want 0", rd_rvalid); end
      checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_lookup_basic();
      logic [7:0] exp;
      drive_lookup({6'b111111, 6'b000000});
      step();
      lk_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_o_valid: got %b want 1", o_valid); end
      checks++; if (o_data !== exp) begin errors++; $display("FAIL basic_o_data: got %h want %h", o_data, exp); end
      checks++; if (o_data !== 8'he7) begin errors++; $display("FAIL basic_s4_corners: got %h want e7", o_data); end
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_o_valid: got %b want 0", o_valid); end
      checks++; if (o_data !== exp) begin errors++; $display("FAIL hold_o_data: got %h want %h", o_data, exp); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      for (int i = 0; i < 12; i++) begin
         drive_lookup(12'($urandom));
         step();
         exp = lk_q.pop_front();
         checks++; if (o_valid !== 1'b1 || o_data !== exp) begin
            errors++; $display("FAIL b2b_lookup[%0d]: got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, exp);
         end
      end
      lk_valid = 1'b0;
      step();
   endtask

   task automatic test_write_own();
      logic [7:0] exp;
      drive_write(3'd3, 2'd1, 4'd2, 4'd9);
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL own_wr_ready: got %b want 1", wr_ready); end
      step();
      wr_valid = 1'b0;
      m_tbl[{2'd1, 4'd2}] = 4'd9;
      drive_lookup({6'b111111, 6'b000101});
      step();
      lk_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_data !== exp) begin errors++; $display("FAIL own_write_lookup: got %h want %h", o_data, exp); end
      checks++; if (o_data[3:0] !== 4'd9) begin errors++; $display("FAIL own_write_value: got %0d want 9", o_data[3:0]); end
   endtask

   task automatic test_write_other();
      logic [7:0] exp;
      drive_write(3'd2, 2'd0, 4'd0, 4'd1);
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL other_wr_ready: got %b want 1", wr_ready); end
      step();
      wr_valid = 1'b0;
      drive_lookup({6'b000101, 6'b000000});
      step();
      lk_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_data !== exp) begin errors++; $display("FAIL other_write_lookup: got %h want %h", o_data, exp); end
      checks++; if (o_data[3:0] !== 4'd7) begin errors++; $display("FAIL other_write_value: got %0d want 7", o_data[3:0]); end
   endtask

   task automatic test_restore();
      int cnt;
      logic [7:0] exp;
      restore_req = 1'b1;
      step();
      restore_req = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL restore_wr_ready[%0d]: got %b want 0", cnt, wr_ready); end
         restore_req = (cnt == 10);
         if (cnt == 20) drive_write(3'd3, 2'd0, 4'd0, 4'd0);
         else wr_valid = 1'b0;
         step();
         cnt++;
      end
      restore_req = 1'b0;
      wr_valid    = 1'b0;
      checks++; if (cnt != 64) begin errors++; $display("FAIL restore_busy_cycles: got %0d want 64", cnt); end
      model_defaults();
      drive_lookup({6'b000000, 6'b000101});
      step();
      lk_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_data !== exp) begin errors++; $display("FAIL restore_lookup: got %h want %h", o_data, exp); end
      checks++; if (o_data[3:0] !== 4'd11) begin errors++; $display("FAIL restore_value: got %0d want 11", o_data[3:0]); end
   endtask

   task automatic test_reset_mid_restore();
      logic [3:0] exp;
      logic [5:0] av;
      drive_write(3'd3, 2'd2, 4'd5, 4'd0);
      step();
      wr_valid    = 1'b0;
      restore_req = 1'b1;
      step();
      restore_req = 1'b0;
      repeat (20) step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
      step();
      rst_n = 1'b1;
      model_defaults();
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
      for (int a = 0; a < 64; a++) begin
         av       = 6'(a);
         rd_valid = 1'b1;
         rd_row   = av[5:4];
         rd_col   = av[3:0];
         rd_q.push_back(m_tbl[av]);
         step();
         exp = rd_q.pop_front();
         checks++; if (rd_rvalid !== 1'b1 || rd_data !== exp) begin
            errors++; $display("FAIL readback[%0d]: got v=%b d=%0d want v=1 d=%0d", a, rd_rvalid, rd_data, exp);
         end
      end
      rd_valid = 1'b0;
      step();
      checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL readback_idle: got %b want 0", rd_rvalid); end
   endtask

   task automatic test_same_cycle();
      logic [7:0] exp;
      drive_write(3'd3, 2'd0, 4'd0, 4'd5);
      drive_lookup({6'b000101, 6'b000000});
      m_tbl[0] = 4'd5;
      step();
      wr_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_data !== exp) begin errors++; $display("FAIL same_cycle_old: got %h want %h", o_data, exp); end
      checks++; if (o_data[3:0] !== 4'd7) begin errors++; $display("FAIL same_cycle_old_value: got %0d want 7", o_data[3:0]); end
      drive_lookup({6'b000101, 6'b000000});
      step();
      lk_valid = 1'b0;
      exp = lk_q.pop_front();
      checks++; if (o_data !== exp) begin errors++; $display("FAIL same_cycle_new: got %h want %h", o_data, exp); end
      checks++; if (o_data[3:0] !== 4'd5) begin errors++; $display("FAIL same_cycle_new_value: got %0d want 5", o_data[3:0]); end
   endtask

   initial begin
      rst_n       = 1'b0;
      lk_valid    = 1'b0;
      lk_data     = '0;
      wr_valid    = 1'b0;
      wr_sel      = '0;
      wr_row      = '0;
      wr_col      = '0;
      wr_data     = '0;
      rd_valid    = 1'b0;
      rd_row      = '0;
      rd_col      = '0;
      restore_req = 1'b0;
      model_defaults();

      test_reset();
      test_lookup_basic();
      test_back_to_back();
      test_write_own();
      test_write_other();
      test_restore();
      test_reset_mid_restore();
      test_same_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_sbox_prog.md
DES_SBOX_PROG -- requirements
Module: des_sbox_prog

Interface
REQ-001 Parameter SBOX_ID, default 0: DES S-box index 0..7; selects the default table and matches wr_sel.
REQ-002 Parameter LANES, default 1: number of parallel lookup lanes sharing one table, legal 1..8.
REQ-003 Parameter OUT_REG, default 1: 1 = registered lookup output, 0 = combinational lookup output.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 lk_valid  in  1  lookup request qualifier, common to all lanes.
REQ-007 lk_data  in  6*LANES  lane k uses bits [6k+5:6k].
REQ-008 o_valid  out  1  lookup result qualifier.
REQ-009 o_data  out  4*LANES  lane k result on bits [4k+3:4k].
REQ-010 wr_valid / wr_ready  in / out  1 / 1  edit handshake.
REQ-011 wr_sel, wr_row, wr_col, wr_data  in  3, 2, 4, 4  target S-box, row, column and new value.
REQ-012 rd_valid  in  1  readback request; rd_row in 2, rd_col in 4.
REQ-013 rd_rvalid / rd_data  out  1 / 4  readback response.
REQ-014 restore_req  in  1  single-cycle pulse; reloads the default table.
REQ-015 busy  out  1  high while a restore is in progress.

Function
REQ-016 Table: 64 entries of 4 bits; address = {row[1:0], col[3:0]}.
REQ-017 Lookup per lane: row = {d[5], d[0]}; col = d[4:1].
REQ-018 OUT_REG=1: o_data and o_valid are registered one cycle after lk_valid. o_data holds its value when lk_valid=0.
REQ-019 OUT_REG=0: o_data is combinational from the current table and o_valid = lk_valid.
REQ-020 Write handshake: a transfer occurs when wr_valid && wr_ready; wr_ready = !busy.
REQ-021 A transfer with wr_sel == SBOX_ID updates the entry at the clock edge. A transfer with any other wr_sel is accepted and discarded.
REQ-022 Write and lookup of the same entry in the same cycle: the lookup returns the old value; the new value is visible from the next cycle.
REQ-023 Readback: rd_valid sampled produces rd_rvalid=1 with rd_data = entry(rd_row, rd_col) one cycle later. Readback is legal while busy.
REQ-024 FSM states: IDLE and RESTORE, with a 6-bit index counter.
- IDLE -> RESTORE on restore_req; index cleared to 0.
- In RESTORE: write default(index) each cycle, index++.
- RESTORE -> IDLE after index 63 is written.
- busy = (state == RESTORE), giving exactly 64 busy cycles.
REQ-025 restore_req while busy is ignored.
REQ-026 restore_req coincident with a write handshake: the write completes first, then restore begins on the next cycle.
REQ-027 Lookups continue during restore and return the current mixed contents; this is not an error.

Reset
REQ-028 On rst_n low, asynchronously:
- table = defaults for SBOX_ID
- state = IDLE, index = 0
- o_valid = 0, o_data = 0
- rd_rvalid = 0, rd_data = 0
REQ-029 Reset asserted mid-restore aborts the restore; the full default table is present on reset release.

Structure
REQ-030 Shared package des_pkg holds the DES S1..S8 default tables and a function des_sbox_default(id, row, col) returning 4 bits.
REQ-031 The package also holds constants SBOX_ROWS=4, SBOX_COLS=16, SBOX_IN_W=6, SBOX_OUT_W=4.
REQ-032 One sub-module, des_sbox_lane, provides the single-lane address decode and mux and is instantiated LANES times.

Verification
REQ-033 Setup: SBOX_ID=3, LANES=2, OUT_REG=1. Reset, then lk_data = {6'b111111, 6'b000000}, lk_valid=1 -> next cycle o_valid=1, o_data = {4'd14, 4'd7}.
REQ-034 Write sel=3, row=1, col=2, data=9, then lookup lane0 = 6'b000101 -> 9 (default value is 11).
REQ-035 Write sel=2, row=0, col=0, data=1 -> wr_ready=1 during the transfer; lookup of 6'b000000 still returns 7.
REQ-036 After REQ-034, pulse restore_req -> busy high for exactly 64 cycles with wr_ready=0; afterwards lookup 6'b000101 -> 11.
REQ-037 Assert rst_n low at restore index 20, then release -> busy=0 and all 64 readbacks match the defaults.
REQ-038 Simultaneous write row=0, col=0, data=5 with lookup 6'b000000 -> returns 7 in that lookup; the next lookup returns 5.
